// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU port A and req/ack master B, one
// transaction at a time, with a watchdog that aborts unanswered requests.
module mem_arbiter #(
  parameter int unsigned RV      = 32,
  parameter int unsigned AW      = 31,
  parameter bit          RR      = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a_addr,
  input  logic            a_ifetch,
  input  logic [1:0]      a_rstrobe,
  input  logic [RV/8-1:0] a_wmask,
  input  logic [RV-1:0]   a_wdata,
  output logic [RV-1:0]   a_rdata,
  output logic            a_rdone,
  output logic            a_wdone,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [RV/8-1:0] b_wmask,
  input  logic [RV-1:0]   b_wdata,
  output logic [RV-1:0]   b_rdata,
  output logic            b_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [RV/8-1:0] m_wmask,
  output logic [RV-1:0]   m_wdata,
  input  logic            m_ack,
  input  logic [RV-1:0]   m_rdata,
  output logic            err
);

  localparam int unsigned MW = RV / 8;
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_A = 2'd1,
    S_BUSY_B = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [MW-1:0]   m_wmask_q, m_wmask_d;
  logic [RV-1:0]   m_wdata_q, m_wdata_d;
  logic [RV-1:0]   a_rdata_q, a_rdata_d;
  logic [RV-1:0]   b_rdata_q, b_rdata_d;
  logic            a_rdone_q, a_rdone_d;
  logic            a_wdone_q, a_wdone_d;
  logic            b_ack_q, b_ack_d;
  logic            err_q, err_d;
  logic            last_b_q, last_b_d;
  logic            a_wr_q, a_wr_d;

  logic            a_pend_c;
  logic            a_wr_c;
  logic            grant_a_c;
  logic [RV-1:0]   rd_c;

  // Next-state, grant and completion logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wmask_d = m_wmask_q;
    m_wdata_d = m_wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    last_b_d  = last_b_q;
    a_wr_d    = a_wr_q;
    a_rdone_d = 1'b0;
    a_wdone_d = 1'b0;
    b_ack_d   = 1'b0;
    err_d     = 1'b0;
    rd_c      = m_rdata;

    a_pend_c  = a_ifetch | (|a_rstrobe) | (|a_wmask);
    a_wr_c    = |a_wmask;
    // On a tie A wins unless round-robin says A went last
    grant_a_c = a_pend_c & (~b_req | (RR == 1'b0) | last_b_q);

    case (state_q)
      S_IDLE: begin
        if (grant_a_c) begin
          state_d   = S_BUSY_A;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = a_wr_c;
          m_addr_d  = a_addr;
          m_wmask_d = a_wr_c ? a_wmask : {MW{1'b1}};
          m_wdata_d = a_wdata;
          a_wr_d    = a_wr_c;
        end else if (b_req) begin
          state_d   = S_BUSY_B;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = b_we;
          m_addr_d  = b_addr;
          m_wmask_d = b_we ? b_wmask : {MW{1'b1}};
          m_wdata_d = b_wdata;
        end
      end
      S_BUSY_A, S_BUSY_B: begin
        if (m_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d  = S_DONE;
          m_req_d  = 1'b0;
          err_d    = ~m_ack;
          rd_c     = m_ack ? m_rdata : {RV{1'b1}};
          last_b_d = (state_q == S_BUSY_B);
          if (state_q == S_BUSY_B) begin
            b_ack_d   = 1'b1;
            b_rdata_d = rd_c;
          end else begin
            a_rdata_d = rd_c;
            a_wdone_d = a_wr_q;
            a_rdone_d = ~a_wr_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // One dead cycle so the requester can drop its level request
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wmask_q <= '0;
      m_wdata_q <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_rdone_q <= 1'b0;
      a_wdone_q <= 1'b0;
      b_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      last_b_q  <= 1'b1;
      a_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wmask_q <= m_wmask_d;
      m_wdata_q <= m_wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_rdone_q <= a_rdone_d;
      a_wdone_q <= a_wdone_d;
      b_ack_q   <= b_ack_d;
      err_q     <= err_d;
      last_b_q  <= last_b_d;
      a_wr_q    <= a_wr_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign a_rdone = a_rdone_q;
  assign a_wdone = a_wdone_q;
  assign b_rdata = b_rdata_q;
  assign b_ack   = b_ack_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wmask = m_wmask_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random transactions against a
// transaction-level model; a second RR=0 instance checks fixed priority.
module tb_mem_arbiter;

  localparam int unsigned RV  = 32;
  localparam int unsigned AW  = 31;
  localparam int unsigned MW  = RV / 8;
  localparam int unsigned TMO = 8;

  typedef struct {
    bit            is_b;
    bit            wr;
    logic [AW-1:0] addr;
    logic [MW-1:0] wmask;
    logic [RV-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset2;
  logic [AW-1:0] a_addr, b_addr, m_addr;
  logic          a_ifetch, b_req, b_we, m_ack;
  logic [1:0]    a_rstrobe;
  logic [MW-1:0] a_wmask, b_wmask, m_wmask;
  logic [RV-1:0] a_wdata, b_wdata, m_rdata, a_rdata, b_rdata, m_wdata;
  logic          a_rdone, a_wdone, b_ack, m_req, m_we, err;

  logic          a2_ifetch, b2_req, m2_ack;
  logic [RV-1:0] a2_rdata, b2_rdata, m2_wdata;
  logic          a2_rdone, a2_wdone, b2_ack, m2_req, m2_we, err2;
  logic [AW-1:0] m2_addr;
  logic [MW-1:0] m2_wmask;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state
  bit            mdl_last_b;
  logic [RV-1:0] mdl_a_rd, mdl_b_rd;

  mem_arbiter #(.RV(RV), .AW(AW), .RR(1'b1), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_ifetch(a_ifetch), .a_rstrobe(a_rstrobe), .a_wmask(a_wmask),
    .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rdone(a_rdone), .a_wdone(a_wdone),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  // Memory behind the fixed-priority instance acks on the first busy cycle
  assign m2_ack = m2_req;

  mem_arbiter #(.RV(RV), .AW(AW), .RR(1'b0), .TIMEOUT(TMO)) dut2 (
    .clk(clk), .reset(reset2),
    .a_addr(AW'(32'h40)), .a_ifetch(a2_ifetch), .a_rstrobe(2'b00), .a_wmask(4'h0),
    .a_wdata(32'h0), .a_rdata(a2_rdata), .a_rdone(a2_rdone), .a_wdone(a2_wdone),
    .b_req(b2_req), .b_we(1'b0), .b_addr(AW'(32'h80)), .b_wmask(4'h0), .b_wdata(32'h0),
    .b_rdata(b2_rdata), .b_ack(b2_ack),
    .m_req(m2_req), .m_we(m2_we), .m_addr(m2_addr), .m_wmask(m2_wmask), .m_wdata(m2_wdata),
    .m_ack(m2_ack), .m_rdata(32'h1234_5678), .err(err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin pick for the RR=1 instance: true when B should win
  function automatic bit pick_b(input bit ap, input bit bp);
    return bp && (!ap || !mdl_last_b);
  endfunction

  task automatic apply_a(input req_t r);
    a_addr  = r.addr;
    a_wdata = r.wdata;
    if (r.wr) begin
      a_wmask   = r.wmask;
      a_ifetch  = 1'($urandom);
      a_rstrobe = 2'($urandom);
    end else begin
      a_wmask   = '0;
      a_rstrobe = 2'($urandom);
      a_ifetch  = (a_rstrobe == 2'b00) ? 1'b1 : 1'($urandom);
    end
  endtask

  task automatic apply_b(input req_t r);
    b_req   = 1'b1;
    b_we    = r.wr;
    b_addr  = r.addr;
    b_wmask = r.wr ? r.wmask : 4'($urandom);
    b_wdata = r.wdata;
  endtask

  task automatic drop_a();
    a_ifetch  = 1'b0;
    a_rstrobe = 2'b00;
    a_wmask   = '0;
  endtask

  task automatic rand_req(input bit is_b, output req_t r);
    r.is_b  = is_b;
    r.wr    = 1'($urandom);
    r.addr  = AW'($urandom);
    r.wmask = 4'($urandom_range(1, 15));
    r.wdata = $urandom;
  endtask

  // Act as memory for one granted transaction; lat = 0 means never ack
  task automatic serve(input req_t r, input int lat, input logic [RV-1:0] rd);
    int n;
    int hi;
    bit to;
    logic [RV-1:0] exp_rd;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_req && n < 8);
    chk("grant_lat", 64'(n), 64'(1));
    chk("m_addr", 64'(m_addr), 64'(r.addr));
    chk("m_we", 64'(m_we), 64'(r.wr));
    chk("m_wmask", 64'(m_wmask), 64'(r.wr ? r.wmask : {MW{1'b1}}));
    chk("m_wdata", 64'(m_wdata), 64'(r.wdata));
    hi = 1;
    for (int k = 1; k <= 40; k++) begin
      m_rdata = $urandom;
      m_ack   = (lat != 0) && (k == lat);
      if (m_ack) m_rdata = rd;
      if (r.is_b) begin
        b_addr  = AW'($urandom);
        b_wdata = $urandom;
      end else begin
        a_addr  = AW'($urandom);
        a_wdata = $urandom;
      end
      tick();
      m_ack = 1'b0;
      if (!m_req) break;
      hi++;
      chk("m_addr_hold", 64'(m_addr), 64'(r.addr));
      chk("busy_quiet", 64'({a_rdone, a_wdone, b_ack, err}), 64'(0));
    end
    to = (lat == 0);
    chk("req_cycles", 64'(hi), 64'(to ? TMO : lat));
    exp_rd = to ? {RV{1'b1}} : rd;
    if (r.is_b) mdl_b_rd = exp_rd;
    else        mdl_a_rd = exp_rd;
    chk("a_rdone", 64'(a_rdone), 64'(!r.is_b && !r.wr));
    chk("a_wdone", 64'(a_wdone), 64'(!r.is_b && r.wr));
    chk("b_ack", 64'(b_ack), 64'(r.is_b));
    chk("err", 64'(err), 64'(to));
    chk("a_rdata", 64'(a_rdata), 64'(mdl_a_rd));
    chk("b_rdata", 64'(b_rdata), 64'(mdl_b_rd));
    if (r.is_b) b_req = 1'b0;
    else        drop_a();
    mdl_last_b = r.is_b;
    tick();
    chk("done_clear", 64'({a_rdone, a_wdone, b_ack, err, m_req}), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_t ra, rb, rw, rl;
    bit   wb;
    int   na, nb, ne;

    reset = 1'b0; reset2 = 1'b0;
    drop_a(); a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wmask = '0; b_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;
    a2_ifetch = 1'b0; b2_req = 1'b0;
    mdl_last_b = 1'b1; mdl_a_rd = '0; mdl_b_rd = '0;
    repeat (3) tick();
    chk("rst_ctl", 64'({m_req, m_we, a_rdone, a_wdone, b_ack, err}), 64'(0));
    chk("rst_wmask", 64'(m_wmask), 64'(0));
    chk("rst_addr", 64'(m_addr), 64'(0));
    chk("rst_wdata", 64'(m_wdata), 64'(0));
    chk("rst_rdata", 64'({a_rdata, b_rdata}), 64'(0));
    reset = 1'b1;
    tick();

    // A instruction fetch read
    ra = '{is_b: 1'b0, wr: 1'b0, addr: AW'(32'h100), wmask: 4'h0, wdata: 32'h0};
    a_addr = ra.addr; a_wdata = ra.wdata; a_ifetch = 1'b1;
    serve(ra, 3, 32'hDEAD_BEEF);

    // A byte write
    rw = '{is_b: 1'b0, wr: 1'b1, addr: AW'(32'h104), wmask: 4'b0100, wdata: 32'h00AA_0000};
    a_addr = rw.addr; a_wdata = rw.wdata; a_wmask = rw.wmask;
    serve(rw, 2, $urandom);

    // Both ports re-requesting back to back alternate under round-robin
    ra = '{is_b: 1'b0, wr: 1'b0, addr: AW'(32'h200), wmask: 4'h0, wdata: 32'h11};
    rb = '{is_b: 1'b1, wr: 1'b0, addr: AW'(32'h300), wmask: 4'h0, wdata: 32'h22};
    apply_a(ra); apply_b(rb);
    for (int i = 0; i < 4; i++) begin
      wb = pick_b(1'b1, 1'b1);
      serve(wb ? rb : ra, 1 + (i % 3), $urandom);
      if (wb) apply_b(rb);
      else    apply_a(ra);
    end
    drop_a(); b_req = 1'b0;

    // B write that memory never acknowledges, then a normal A read
    rb = '{is_b: 1'b1, wr: 1'b1, addr: AW'(32'h20), wmask: 4'hF, wdata: 32'hCAFE_F00D};
    apply_b(rb);
    serve(rb, 0, 32'h0);
    ra = '{is_b: 1'b0, wr: 1'b0, addr: AW'(32'h400), wmask: 4'h0, wdata: 32'h0};
    apply_a(ra);
    serve(ra, 1, 32'h5555_AAAA);

    // Ack arriving on the last cycle before the watchdog fires
    apply_a(ra);
    serve(ra, TMO, 32'h0BAD_CAFE);

    // B read held through done, dropped in the done cycle
    rb = '{is_b: 1'b1, wr: 1'b0, addr: AW'(32'h44), wmask: 4'h0, wdata: 32'h0};
    apply_b(rb);
    serve(rb, 2, 32'h7777_1234);
    tick();
    chk("no_dup_req", 64'({m_req, b_ack}), 64'(0));

    // Reset in the middle of an A transaction
    a_addr = AW'(32'h500); a_ifetch = 1'b1;
    tick();
    chk("pre_rst_req", 64'(m_req), 64'(1));
    tick();
    reset = 1'b0;
    tick();
    mdl_last_b = 1'b1; mdl_a_rd = '0; mdl_b_rd = '0;
    chk("midrst_ctl", 64'({m_req, m_we, a_rdone, a_wdone, b_ack, err}), 64'(0));
    chk("midrst_addr", 64'(m_addr), 64'(0));
    chk("midrst_rdata", 64'(a_rdata), 64'(mdl_a_rd));
    drop_a(); reset = 1'b1;
    m_ack = 1'b1; m_rdata = 32'hFFFF_0000;
    tick();
    m_ack = 1'b0;
    tick();
    chk("late_ack", 64'({m_req, a_rdone, a_wdone, b_ack, err}), 64'(0));
    chk("late_ack_rd", 64'(a_rdata), 64'(mdl_a_rd));

    // Random traffic: A only, B only, or both at once
    for (int t = 0; t < 40; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      rand_req(1'b0, ra);
      rand_req(1'b1, rb);
      if (mode == 0) begin
        apply_a(ra);
        serve(ra, $urandom_range(0, TMO), $urandom);
      end else if (mode == 1) begin
        apply_b(rb);
        serve(rb, $urandom_range(0, TMO), $urandom);
      end else begin
        apply_a(ra); apply_b(rb);
        wb = pick_b(1'b1, 1'b1);
        rl = wb ? ra : rb;
        serve(wb ? rb : ra, $urandom_range(0, TMO), $urandom);
        serve(rl, $urandom_range(0, TMO), $urandom);
      end
    end

    // Fixed priority: A held continuously keeps B waiting
    a2_ifetch = 1'b1; b2_req = 1'b1; reset2 = 1'b1;
    na = 0; nb = 0; ne = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      na += int'(a2_rdone);
      nb += int'(b2_ack);
      ne += int'(err2 | a2_wdone);
    end
    chk("fp_b_starved", 64'(nb), 64'(0));
    chk("fp_a_served", 64'(na >= 5), 64'(1));
    a2_ifetch = 1'b0;
    nb = 0;
    for (int c = 0; c < 12 && nb == 0; c++) begin
      tick();
      nb += int'(b2_ack);
      ne += int'(err2 | a2_wdone);
    end
    chk("fp_b_after", 64'(nb), 64'(1));
    chk("fp_no_err", 64'(ne), 64'(0));
    chk("fp_m_addr", 64'(m2_addr), 64'(32'h80));
    chk("fp_m_rd", 64'({m2_we, m2_wmask}), 64'(5'b0_1111));
    chk("fp_m_wdata", 64'(m2_wdata), 64'(0));
    chk("fp_rdata", 64'({a2_rdata, b2_rdata}), 64'({32'h1234_5678, 32'h1234_5678}));
    b2_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
